// File: rtl/serial_pkg.sv
// Shared encodings for the serial transmit path: FSM state codes and line levels.
package serial_pkg;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/serial_tx_if.sv
// Load/Data request side and Ready/Busy/TxOut status side of the transmitter.
interface serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] Data;
  logic              Load;
  logic              Ready;
  logic              Busy;
  logic              TxOut;

  modport master (output Data, Load, input Ready, Busy, TxOut);
  modport slave  (input Data, Load, output Ready, Busy, TxOut);
endinterface

// File: rtl/serial_bit_timer.sv
// Per-bit cycle counter: pulses BitDone on the last cycle of each bit while Run is high.
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  output logic BitDone
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TC = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign BitDone = Run && (cnt == TC);

  always_ff @(posedge Clk) begin
    if (Reset || !Run)  cnt <= '0;
    else if (BitDone)   cnt <= '0;
    else                cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/serial_tx.sv
// Framed serial transmitter: start 0, DATA_W bits LSB-first, stop 1; line idles high.
// Optional even-parity bit before stop when SERIAL_TX_PARITY_EN is defined.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  serial_tx_if.slave  tx
);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] LAST = IW'(DATA_W - 1);

  logic [2:0]        state;
  logic [DATA_W-1:0] shreg;
  logic [IW-1:0]     bit_idx;
  logic              tx_q;
  logic              ready_q;
  logic              bit_done;
`ifdef SERIAL_TX_PARITY_EN
  logic              par_q;
`endif

  assign tx.TxOut = tx_q;
  assign tx.Ready = ready_q;
  assign tx.Busy  = ~ready_q;

  serial_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .Clk     (Clk),
    .Reset   (Reset),
    .Run     (state != S_IDLE),
    .BitDone (bit_done)
  );

  // tx_q is loaded with the level of the state being entered, so each bit
  // appears on the line on the same edge as the state change.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      tx_q    <= LINE_IDLE;
      ready_q <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (tx.Load && ready_q) begin
          state   <= S_START;
          shreg   <= tx.Data;
          tx_q    <= START_BIT;
          ready_q <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
          par_q   <= ^tx.Data;
`endif
        end
        S_START: if (bit_done) begin
          state <= S_DATA;
          tx_q  <= shreg[0];
          shreg <= shreg >> 1;
        end
        S_DATA: if (bit_done) begin
          if (bit_idx == LAST) begin
            bit_idx <= '0;
`ifdef SERIAL_TX_PARITY_EN
            state   <= S_PARITY;
            tx_q    <= par_q;
`else
            state   <= S_STOP;
            tx_q    <= STOP_BIT;
`endif
          end else begin
            bit_idx <= bit_idx + 1'b1;
            tx_q    <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY: if (bit_done) begin
          state <= S_STOP;
          tx_q  <= STOP_BIT;
        end
`endif
        S_STOP: if (bit_done) begin
          state   <= S_IDLE;
          tx_q    <= LINE_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          tx_q    <= LINE_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: expected {Ready,TxOut} per cycle queued at stimulus time, checked each negedge.
module tb_serial_tx;
  localparam int DW  = 8;
  localparam int CPB = 4;

  logic Clk = 1'b0;
  logic Reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [1:0] expq[$];

  serial_tx_if #(.DATA_W(DW)) bus ();

  serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .tx    (bus.slave)
  );

  always #5 Clk = ~Clk;

  task automatic push_bit(input logic b);
    for (int k = 0; k < CPB; k++) expq.push_back({1'b0, b});
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) expq.push_back(2'b11);
  endtask

  task automatic push_frame(input logic [DW-1:0] d);
    push_bit(1'b0);
    for (int i = 0; i < DW; i++) push_bit(d[i]);
`ifdef SERIAL_TX_PARITY_EN
    push_bit(^d);
`endif
    push_bit(1'b1);
  endtask

  task automatic drain(input int n, input string tag);
    logic [1:0] exp;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      n_tests++;
      if (expq.size() == 0) begin
        n_fail++;
        $display("FAIL %s: scoreboard empty at step %0d", tag, i);
      end else begin
        exp = expq.pop_front();
        assert ({bus.Ready, bus.TxOut} === exp) else begin
          n_fail++;
          $error("FAIL %s step %0d: {Ready,TxOut} got %b exp %b", tag, i, {bus.Ready, bus.TxOut}, exp);
        end
        n_tests++;
        assert (bus.Busy === ~exp[1]) else begin
          n_fail++;
          $error("FAIL %s step %0d: Busy got %b exp %b", tag, i, bus.Busy, ~exp[1]);
        end
      end
    end
  endtask

  initial begin
    // Reset held with Load high: no frame may start.
    Reset = 1'b1; bus.Load = 1'b1; bus.Data = 8'hA5;
    push_idle(2);
    drain(2, "reset");
    Reset = 1'b0; bus.Load = 1'b0;
    push_idle(20);
    drain(20, "idle");

    // Single 8'hA5 frame, with an ignored Load of 8'hFF mid-frame.
    bus.Data = 8'hA5; bus.Load = 1'b1;
    push_frame(8'hA5);
    push_idle(1);
    drain(1, "a5_accept");
    bus.Load = 1'b0;
    drain(9, "a5_frame");
    bus.Data = 8'hFF; bus.Load = 1'b1;
    drain(1, "a5_ignload");
    bus.Load = 1'b0;
    drain(expq.size(), "a5_tail");
    push_idle(20);
    drain(20, "a5_noframe");

    // Back-to-back with Load held: 8'h00 then 8'hFF, one idle cycle between.
    bus.Data = 8'h00; bus.Load = 1'b1;
    push_frame(8'h00);
    push_idle(1);
    push_frame(8'hFF);
    push_idle(1);
    drain(1, "b2b_first");
    bus.Data = 8'hFF;
    drain(CPB * (DW + 2) + 1, "b2b_gap");
`ifdef SERIAL_TX_PARITY_EN
    drain(CPB, "b2b_parity");
`endif
    drain(1, "b2b_second");
    bus.Load = 1'b0;
    drain(expq.size(), "b2b_tail");
    push_idle(5);
    drain(5, "b2b_idle");

    // Abort: reset in cycle 15 of an 8'h3C frame, then a clean 8'h81 frame.
    bus.Data = 8'h3C; bus.Load = 1'b1;
    push_frame(8'h3C);
    drain(1, "abort_accept");
    bus.Load = 1'b0;
    drain(14, "abort_frame");
    expq.delete();
    Reset = 1'b1;
    push_idle(1);
    drain(1, "abort_reset");
    Reset = 1'b0;
    push_idle(3);
    drain(3, "abort_idle");
    bus.Data = 8'h81; bus.Load = 1'b1;
    push_frame(8'h81);
    push_idle(1);
    drain(1, "h81_accept");
    bus.Load = 1'b0;
    drain(expq.size(), "h81_frame");

`ifdef SERIAL_TX_PARITY_EN
    // Odd-weight byte: parity bit 1, 44-cycle frame.
    bus.Data = 8'h07; bus.Load = 1'b1;
    push_frame(8'h07);
    push_idle(1);
    n_tests++;
    assert (expq.size() == 45) else begin
      n_fail++;
      $error("FAIL par_len: queued %0d exp 45", expq.size());
    end
    drain(1, "h07_accept");
    bus.Load = 1'b0;
    drain(expq.size(), "h07_frame");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
